board_store: RTL and testbench
==============================

// Module: board_store
// PURPOSE
// Playfield storage and line-clear engine: the owner/writer side of the board memory that the
// pixel renderer reads. Holds one 3-bit block type per cell, answers the renderer's row/column
// selectors combinationally, accepts cell writes from game logic via valid/ready, and runs a
// row-clear sequence (scan full rows, shift rows above down) on command.
// PARAMETERS
// BLOCKS_VERTICAL    12  number of rows (row 0 = top)
// BLOCKS_HORIZONTAL  21  number of columns
// CNT_W              5   width of lines_cleared counter
// PORTS
// clk_25_175     in   1      pixel/system clock
// reset          in   1      synchronous, active-high reset
// memselector_v  in   5      renderer row select
// memselector_h  in   5      renderer column select
// blocktype_mem  out  3      cell type at (memselector_v, memselector_h); 0 = empty
// rd_v, rd_h     in   5 each game-side collision read address
// rd_type        out  3      cell type at (rd_v, rd_h)
// wr_valid       in   1      game write request
// wr_ready       out  1      write accepted this cycle when wr_valid & wr_ready
// wr_v, wr_h     in   5 each write address
// wr_type        in   3      value to write (0 erases)
// clr_start      in   1      one-cycle pulse: start line-clear sequence
// wipe_start     in   1      one-cycle pulse: zero whole board
// busy           out  1      high in SCAN/SHIFT/WIPE/DONE
// clr_done       out  1      one-cycle pulse at end of clear or wipe
// lines_cleared  out  CNT_W  rows removed by last clear sequence
// BEHAVIOUR
// - Reset (sync, high): all cells 0, state IDLE, busy=0, clr_done=0, lines_cleared=0,
//   wr_ready=0 during reset cycle. Reset mid-sequence aborts immediately; no partial shift kept.
// - Read ports purely combinational, zero latency; out-of-range address (v>=ROWS or h>=COLS)
//   returns 0. Reads reflect register contents; an edge-committed write/shift is visible next cycle.
// - wr_ready = (state==IDLE) & !clr_start & !wipe_start & !reset. Accepted write commits at the
//   same edge. Out-of-range write address: handshake completes, data dropped.
// - Start priority in IDLE: wipe_start > clr_start > write. Starts outside IDLE are ignored.
// - FSM: IDLE, WIPE, SCAN, SHIFT, DONE.
//   IDLE -wipe_start-> WIPE (row ptr r=0). WIPE: zero row r per cycle; r==ROWS-1 -> DONE.
//   IDLE -clr_start-> SCAN (r=ROWS-1, lines_cleared<=0).
//   SCAN: row r full (every cell !=0) -> SHIFT; else r==0 -> DONE, else r<=r-1.
//   SHIFT (1 cycle): rows 1..r take rows 0..r-1, row 0 zeroed, lines_cleared+=1 saturating at
//   2^CNT_W-1; return to SCAN with same r (re-check shifted-in row).
//   DONE: clr_done=1 for exactly this cycle, busy=1; next state IDLE.
// - Clear latency: ROWS scan cycles + 2 cycles per cleared row + 1 DONE cycle.
//   Wipe latency: ROWS + 1 cycles.
// - lines_cleared holds its value until next clr_start; wipe does not change it.
// - Renderer may read during SHIFT/WIPE; tearing of one frame is acceptable.
// TESTING
// - Reset: after reset, all 12x21 reads via memselector = 0; busy=0, wr_ready=1, lines_cleared=0.
// - Write/read: write (3,7,type 5) -> next cycle blocktype_mem@(3,7)=5, rd_type@(3,7)=5;
//   write (12,0,type 2) completes handshake, no cell changes; read (20,25) = 0.
// - Single clear: fill row 11 with type 1, put type 4 at (10,0); clr_start -> clr_done after
//   12+2+1 cycles, lines_cleared=1, (11,0)=4, row 10 all 0.
// - Double clear: rows 10 and 11 full, type 3 at (9,5) -> lines_cleared=2, (11,5)=3, latency 12+4+1.
// - Arbitration: wipe_start, clr_start, wr_valid same IDLE cycle -> wipe runs, clear ignored,
//   write not accepted (wr_ready=0); after ROWS+1 cycles board all 0, clr_done pulse.
// - Reset mid-SHIFT -> next cycle state IDLE, all cells 0, busy=0, no clr_done pulse.

Source files
------------

// File: rtl/board_store.sv
// Playfield cell storage with renderer/game read ports, a game write port and a
// line-clear / wipe sequencer that owns the board while busy.
module board_store #(
  parameter int BLOCKS_VERTICAL   = 12,
  parameter int BLOCKS_HORIZONTAL = 21,
  parameter int CNT_W             = 5
) (
  input  logic             clk_25_175,
  input  logic             reset,
  input  logic [4:0]       memselector_v,
  input  logic [4:0]       memselector_h,
  output logic [2:0]       blocktype_mem,
  input  logic [4:0]       rd_v,
  input  logic [4:0]       rd_h,
  output logic [2:0]       rd_type,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_v,
  input  logic [4:0]       wr_h,
  input  logic [2:0]       wr_type,
  input  logic             clr_start,
  input  logic             wipe_start,
  output logic             busy,
  output logic             clr_done,
  output logic [CNT_W-1:0] lines_cleared,
  output logic [2:0]       state_o
);
  localparam int ROWS = BLOCKS_VERTICAL;
  localparam int COLS = BLOCKS_HORIZONTAL;
  localparam int RW   = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WIPE  = 3'd1,
    S_SCAN  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [RW-1:0]    r_q;
  logic             busy_q;
  logic             clr_done_q;
  logic [CNT_W-1:0] lines_q;
  logic [2:0]       board_q [ROWS][COLS];
  logic             row_full;

  // Out-of-range coordinates match no cell and therefore read as empty.
  function automatic logic [2:0] cell_at(input logic [4:0] v, input logic [4:0] h);
    logic [2:0] t;
    t = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        if (v == 5'(i) && h == 5'(j)) t = board_q[i][j];
    return t;
  endfunction

  assign blocktype_mem = cell_at(memselector_v, memselector_h);
  assign rd_type       = cell_at(rd_v, rd_h);

  // Write handshake: a write transfers on any rising edge where wr_valid && wr_ready;
  // wr_ready is only offered in IDLE when no sequence start is competing that cycle.
  assign wr_ready = (state_q == S_IDLE) & ~clr_start & ~wipe_start & ~reset;

  always_comb begin
    row_full = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_q == RW'(i)) begin
        row_full = 1'b1;
        for (int j = 0; j < COLS; j++)
          if (board_q[i][j] == 3'd0) row_full = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (reset) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      lines_q    <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          board_q[i][j] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wipe_start) begin
            state_q <= S_WIPE;
            r_q     <= '0;
            busy_q  <= 1'b1;
          end else if (clr_start) begin
            state_q <= S_SCAN;
            r_q     <= LAST_ROW;
            lines_q <= '0;
            busy_q  <= 1'b1;
          end else if (wr_valid) begin
            for (int i = 0; i < ROWS; i++)
              for (int j = 0; j < COLS; j++)
                if (wr_v == 5'(i) && wr_h == 5'(j)) board_q[i][j] <= wr_type;
          end
        end
        S_WIPE: begin
          for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
              if (r_q == RW'(i)) board_q[i][j] <= '0;
          if (r_q == LAST_ROW) begin
            state_q    <= S_DONE;
            clr_done_q <= 1'b1;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        S_SCAN: begin
          if (row_full) begin
            state_q <= S_SHIFT;
          end else if (r_q == '0) begin
            state_q    <= S_DONE;
            clr_done_q <= 1'b1;
          end else begin
            r_q <= r_q - 1'b1;
          end
        end
        S_SHIFT: begin
          // r stays put so the row that dropped into it is checked again.
          for (int i = 1; i < ROWS; i++)
            if (RW'(i) <= r_q) board_q[i] <= board_q[i-1];
          for (int j = 0; j < COLS; j++) board_q[0][j] <= '0;
          if (lines_q != '1) lines_q <= lines_q + 1'b1;
          state_q <= S_SCAN;
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign clr_done      = clr_done_q;
  assign lines_cleared = lines_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_board_store.sv
// Directed bench for board_store: reset, writes/reads, single and double line clears,
// start arbitration and reset during a shift.
module tb_board_store;
  logic       clk_25_175 = 1'b0;
  logic       reset;
  logic [4:0] memselector_v, memselector_h;
  logic [2:0] blocktype_mem;
  logic [4:0] rd_v, rd_h;
  logic [2:0] rd_type;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_v, wr_h;
  logic [2:0] wr_type;
  logic       clr_start, wipe_start;
  logic       busy, clr_done;
  logic [4:0] lines_cleared;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  board_store dut (
    .clk_25_175   (clk_25_175),
    .reset        (reset),
    .memselector_v(memselector_v),
    .memselector_h(memselector_h),
    .blocktype_mem(blocktype_mem),
    .rd_v         (rd_v),
    .rd_h         (rd_h),
    .rd_type      (rd_type),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_v         (wr_v),
    .wr_h         (wr_h),
    .wr_type      (wr_type),
    .clr_start    (clr_start),
    .wipe_start   (wipe_start),
    .busy         (busy),
    .clr_done     (clr_done),
    .lines_cleared(lines_cleared),
    .state_o      (state_o)
  );

  // clock / reset
  always #20 clk_25_175 = ~clk_25_175;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25_175);
    @(negedge clk_25_175);
  endtask

  task automatic do_write(input int v, input int h, input int t);
    wr_valid = 1'b1;
    wr_v     = 5'(v);
    wr_h     = 5'(h);
    wr_type  = 3'(t);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic fill_row(input int v, input int t);
    for (int h = 0; h < 21; h++) do_write(v, h, t);
  endtask

  task automatic read_cell(input int v, input int h, output int t);
    memselector_v = 5'(v);
    memselector_h = 5'(h);
    #1;
    t = int'(blocktype_mem);
  endtask

  // Counts nonzero cells over the whole board; the board is quiescent while it runs.
  task automatic count_nz(output int n);
    int t;
    n = 0;
    for (int v = 0; v < 12; v++)
      for (int h = 0; h < 21; h++) begin
        read_cell(v, h, t);
        if (t != 0) n++;
      end
    @(negedge clk_25_175);
  endtask

  // Pulses a start and returns the number of edges up to and including the one
  // that raises clr_done (equals the sequence's busy-cycle count).
  task automatic run_seq(input logic do_wipe, output int n);
    if (do_wipe) wipe_start = 1'b1; else clr_start = 1'b1;
    tick();
    wipe_start = 1'b0;
    clr_start  = 1'b0;
    n = 1;
    while (!clr_done && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, t;
    reset = 1'b1; memselector_v = '0; memselector_h = '0; rd_v = '0; rd_h = '0;
    wr_valid = 1'b0; wr_v = '0; wr_h = '0; wr_type = '0; clr_start = 1'b0; wipe_start = 1'b0;
    @(negedge clk_25_175);
    tick();
    check("wr_ready_in_reset", wr_ready, 0);
    reset = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_wr_ready", wr_ready, 1);
    check("reset_lines", lines_cleared, 0);
    check("reset_clr_done", clr_done, 0);
    check("reset_state", state_o, 0);
    count_nz(n);
    check("reset_board_nz", n, 0);

    // write / read
    wr_valid = 1'b1; wr_v = 5'd3; wr_h = 5'd7; wr_type = 3'd5;
    #1 check("wr_ready_idle", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    read_cell(3, 7, t);
    check("mem_3_7", t, 5);
    rd_v = 5'd3; rd_h = 5'd7; #1;
    check("rd_3_7", rd_type, 5);
    do_write(12, 0, 2);
    count_nz(n);
    check("oob_write_dropped_nz", n, 1);
    rd_v = 5'd20; rd_h = 5'd25; #1;
    check("rd_oob", rd_type, 0);
    read_cell(20, 25, t);
    check("mem_oob", t, 0);
    @(negedge clk_25_175);

    // single clear
    do_write(3, 7, 0);
    fill_row(11, 1);
    do_write(10, 0, 4);
    run_seq(1'b0, n);
    check("single_latency", n, 15);
    check("single_done_busy", busy, 1);
    tick();
    check("single_done_pulse", clr_done, 0);
    check("single_idle_busy", busy, 0);
    check("single_lines", lines_cleared, 1);
    read_cell(11, 0, t);
    check("single_cell_11_0", t, 4);
    rd_v = 5'd10; rd_h = 5'd0; #1;
    check("single_rd_10_0", rd_type, 0);
    count_nz(n);
    check("single_board_nz", n, 1);

    // double clear
    fill_row(10, 1);
    fill_row(11, 1);
    do_write(9, 5, 3);
    run_seq(1'b0, n);
    check("double_latency", n, 17);
    tick();
    check("double_lines", lines_cleared, 2);
    read_cell(11, 5, t);
    check("double_cell_11_5", t, 3);
    count_nz(n);
    check("double_board_nz", n, 1);

    // arbitration: wipe beats clear and write
    do_write(0, 0, 6);
    wipe_start = 1'b1; clr_start = 1'b1;
    wr_valid = 1'b1; wr_v = 5'd5; wr_h = 5'd5; wr_type = 3'd7;
    #1 check("arb_wr_ready", wr_ready, 0);
    tick();
    wipe_start = 1'b0; clr_start = 1'b0; wr_valid = 1'b0;
    check("arb_state_wipe", state_o, 1);
    n = 1;
    while (!clr_done && n < 200) begin
      tick();
      n++;
    end
    check("wipe_latency", n, 13);
    tick();
    check("wipe_lines_kept", lines_cleared, 2);
    check("wipe_busy_off", busy, 0);
    count_nz(n);
    check("wipe_board_nz", n, 0);

    // reset during SHIFT
    fill_row(11, 2);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    check("pre_reset_state_shift", state_o, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", state_o, 0);
    check("abort_busy", busy, 0);
    check("abort_clr_done", clr_done, 0);
    check("abort_lines", lines_cleared, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (clr_done) n++;
      tick();
    end
    check("abort_no_done_pulse", n, 0);
    count_nz(n);
    check("abort_board_nz", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
